// File: rtl/fetch_decode_reg.sv
// MIPS fetch stage: PC register, IF/ID pipeline register and
// field split of the latched instruction word.
module fetch_decode_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm16,
    output logic [25:0] id_target26,
    output logic [31:0] fetch_count
);

    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc_plus4;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_reset_pc;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_reset_pc    = {RESET_PC[31:2], 2'b00};

    // PC and IF/ID update: redirect beats stall beats memory wait
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= w_reset_pc;
            r_id_valid    <= 1'b0;
            r_id_instr    <= NOP_INSTR;
            r_id_pc_plus4 <= 32'd0;
            r_fetch_count <= 32'd0;
        end else if (redirect) begin
            r_pc       <= w_redirect_pc;
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
        end else if (stall) begin
            r_pc       <= r_pc;
            r_id_valid <= r_id_valid;
        end else if (!imem_valid) begin
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
        end else begin
            r_pc          <= w_pc_plus4;
            r_id_valid    <= 1'b1;
            r_id_instr    <= imem_rdata;
            r_id_pc_plus4 <= w_pc_plus4;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign imem_addr   = r_pc;
    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc_plus4 = r_id_pc_plus4;
    assign fetch_count = r_fetch_count;

    assign id_opcode   = r_id_instr[31:26];
    assign id_rs       = r_id_instr[25:21];
    assign id_rt       = r_id_instr[20:16];
    assign id_rd       = r_id_instr[15:11];
    assign id_shamt    = r_id_instr[10:6];
    assign id_funct    = r_id_instr[5:0];
    assign id_imm16    = r_id_instr[15:0];
    assign id_target26 = r_id_instr[25:0];

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Scoreboard bench for fetch_decode_reg: stimulus queues expected
// state per cycle, a negedge monitor pops and compares.
module tb_fetch_decode_reg;

    typedef struct {
        logic [31:0] addr;
        logic        v;
        logic [31:0] instr;
        logic [31:0] p4;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
    logic [25:0] id_target26;
    logic [31:0] fetch_count;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_decode_reg #(
        .RESET_PC (32'h0000_0400),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc_plus4(id_pc_plus4),
        .id_opcode  (id_opcode),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_shamt   (id_shamt),
        .id_funct   (id_funct),
        .id_imm16   (id_imm16),
        .id_target26(id_target26),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] a, input logic v,
                                input logic [31:0] i, input logic [31:0] p,
                                input logic [31:0] c);
        exp_t e;
        e.addr  = a;
        e.v     = v;
        e.instr = i;
        e.p4    = p;
        e.cnt   = c;
        return e;
    endfunction

    function automatic void chk(input string n, input logic [31:0] a,
                                input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endfunction

    // Monitor: compare every queued expectation at the falling edge
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("imem_addr", imem_addr, e.addr);
            chk("id_valid", {31'd0, id_valid}, {31'd0, e.v});
            chk("id_instr", id_instr, e.instr);
            chk("id_pc_plus4", id_pc_plus4, e.p4);
            chk("fetch_count", fetch_count, e.cnt);
            chk("id_opcode", {26'd0, id_opcode}, {26'd0, e.instr[31:26]});
            chk("id_rs", {27'd0, id_rs}, {27'd0, e.instr[25:21]});
            chk("id_rt", {27'd0, id_rt}, {27'd0, e.instr[20:16]});
            chk("id_rd", {27'd0, id_rd}, {27'd0, e.instr[15:11]});
            chk("id_shamt", {27'd0, id_shamt}, {27'd0, e.instr[10:6]});
            chk("id_funct", {26'd0, id_funct}, {26'd0, e.instr[5:0]});
            chk("id_imm16", {16'd0, id_imm16}, {16'd0, e.instr[15:0]});
            chk("id_target26", {6'd0, id_target26}, {6'd0, e.instr[25:0]});
        end
    end

    task automatic cyc(input logic s, input logic r, input logic [31:0] rpc,
                       input logic v, input logic [31:0] rd, input exp_t e);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_valid  = v;
        imem_rdata  = rd;
        @(posedge clk);
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_valid  = 1'b0;
        imem_rdata  = 32'd0;

        // T1 reset
        @(posedge clk);
        @(posedge clk);
        q.push_back(mk(32'h400, 1'b0, 32'h0, 32'h0, 32'd0));
        @(negedge clk);
        rst = 1'b0;

        // T2 sequential fetch
        cyc(0, 0, 0, 1, 32'h2008FFFF,
            mk(32'h404, 1, 32'h2008FFFF, 32'h404, 1));
        cyc(0, 0, 0, 1, 32'h8D09000C,
            mk(32'h408, 1, 32'h8D09000C, 32'h408, 2));

        // T3 stall for 3 cycles
        for (int k = 0; k < 3; k++)
            cyc(1, 0, 0, 1, 32'hDEADBEEF,
                mk(32'h408, 1, 32'h8D09000C, 32'h408, 2));

        // T4 redirect with stall, misaligned target
        cyc(1, 1, 32'h1003, 1, 32'h12345678,
            mk(32'h1000, 0, 32'h0, 32'h408, 2));

        // T5 memory wait then resume
        for (int k = 0; k < 2; k++)
            cyc(0, 0, 0, 0, 32'h11111111,
                mk(32'h1000, 0, 32'h0, 32'h408, 2));
        cyc(0, 0, 0, 1, 32'h014B4820,
            mk(32'h1004, 1, 32'h014B4820, 32'h1004, 3));

        // redirect during memory wait, to top of address space
        cyc(0, 1, 32'hFFFFFFFE, 0, 32'h0,
            mk(32'hFFFFFFFC, 0, 32'h0, 32'h1004, 3));

        // T6 wrap of pc+4
        cyc(0, 0, 0, 1, 32'h08000100,
            mk(32'h0, 1, 32'h08000100, 32'h0, 4));

        // stall outranks memory wait
        cyc(1, 0, 0, 0, 32'h0,
            mk(32'h0, 1, 32'h08000100, 32'h0, 4));

        // async reset asserted and checked between rising edges
        stall      = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'h3C01ABCD;
        @(posedge clk);
        #2 rst = 1'b1;
        q.push_back(mk(32'h400, 0, 32'h0, 32'h0, 0));
        @(negedge clk);
        #1 rst = 1'b0;

        // first fetch after reset comes from RESET_PC
        cyc(0, 0, 0, 1, 32'h3C01ABCD,
            mk(32'h404, 1, 32'h3C01ABCD, 32'h404, 1));

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
